// File: rtl/rggen_irq_coalescer.sv
// Interrupt coalescer: merges enable/status pairs into one irq line with edge counting,
// count-threshold and timeout coalescing, acknowledge, and a level-OR bypass when threshold is 0.
module rggen_irq_coalescer #(
    parameter int TOTAL_INTERRUPTS = 2,
    parameter int COUNT_WIDTH      = 8,
    parameter int TIMER_WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [TOTAL_INTERRUPTS-1:0] i_ier,
    input  logic [TOTAL_INTERRUPTS-1:0] i_isr,
    input  logic [COUNT_WIDTH-1:0]      i_threshold,
    input  logic [TIMER_WIDTH-1:0]      i_timeout,
    input  logic                        i_ack,
    output logic                        o_irq,
    output logic [COUNT_WIDTH-1:0]      o_pending_count,
    output logic [1:0]                  o_state
);

    localparam int PW = $clog2(TOTAL_INTERRUPTS + 1);
    localparam int SW = COUNT_WIDTH + 1;

    // o_state encoding: 0 = IDLE, 1 = COLLECT, 2 = ASSERT.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ASSERT  = 2'd2
    } state_e;

    state_e                      state;
    state_e                      state_next;
    logic [TOTAL_INTERRUPTS-1:0] active;
    logic [TOTAL_INTERRUPTS-1:0] active_q;
    logic [TOTAL_INTERRUPTS-1:0] rise;
    logic [PW-1:0]               events;
    logic [SW-1:0]               sum;
    logic [COUNT_WIDTH-1:0]      count;
    logic [COUNT_WIDTH-1:0]      count_d;
    logic [COUNT_WIDTH-1:0]      count_sat;
    logic [COUNT_WIDTH-1:0]      count_rise;
    logic [TIMER_WIDTH-1:0]      timer;
    logic [TIMER_WIDTH-1:0]      timer_d;
    logic [TIMER_WIDTH-1:0]      timer_dec;
    logic                        irq_q;
    logic                        irq_d;
    logic                        bypass;
    logic                        timeout_on;

    assign active     = i_ier & i_isr;
    assign rise       = active & ~active_q;
    assign bypass     = (i_threshold == '0);
    assign timeout_on = (i_timeout != '0);

    always_comb begin
        events = '0;
        for (int i = 0; i < TOTAL_INTERRUPTS; i++) begin
            if (rise[i]) begin
                events = events + PW'(1);
            end
        end
    end

    // Counter saturates at all-ones instead of wrapping.
    assign sum        = {1'b0, count} + SW'(events);
    assign count_sat  = sum[COUNT_WIDTH] ? '1 : sum[COUNT_WIDTH-1:0];
    assign count_rise = COUNT_WIDTH'(events);
    assign timer_dec  = (timer == '0) ? '0 : timer - TIMER_WIDTH'(1);

    always_comb begin
        state_next = state;
        count_d    = count;
        timer_d    = timer;
        irq_d      = 1'b0;
        if (bypass) begin
            state_next = IDLE;
            count_d    = '0;
            timer_d    = '0;
            irq_d      = |active;
        end else begin
            case (state)
                IDLE: begin
                    if (rise != '0) begin
                        count_d = count_sat;
                        if (count_sat >= i_threshold) begin
                            state_next = ASSERT;
                        end else begin
                            state_next = COLLECT;
                            timer_d    = i_timeout;
                        end
                    end
                end
                COLLECT: begin
                    count_d = count_sat;
                    if (timeout_on) begin
                        timer_d = timer_dec;
                    end
                    if ((count_sat >= i_threshold) || (timeout_on && timer_dec == '0)) begin
                        state_next = ASSERT;
                    end
                end
                ASSERT: begin
                    count_d = count_sat;
                    // Ack or full retirement restarts counting from this cycle's new edges only.
                    if (i_ack || active == '0) begin
                        count_d = count_rise;
                        if (events == '0) begin
                            state_next = IDLE;
                        end else if (count_rise >= i_threshold) begin
                            state_next = ASSERT;
                        end else begin
                            state_next = COLLECT;
                            timer_d    = i_timeout;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    count_d    = '0;
                end
            endcase
            irq_d = (state_next == ASSERT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            timer    <= '0;
            active_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_d;
            timer    <= timer_d;
            active_q <= active;
            irq_q    <= irq_d;
        end
    end

    assign o_irq           = irq_q;
    assign o_pending_count = count;
    assign o_state         = state;

endmodule

// File: tb/tb_rggen_irq_coalescer.sv
// Bench for rggen_irq_coalescer: two instances (8-bit and 2-bit counters) share stimulus;
// a reference model pushes expected {state, irq, count} per cycle and a monitor compares.
module tb_rggen_irq_coalescer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ier = '0;
    logic [1:0]  isr = '0;
    logic        ack = 1'b0;
    logic [7:0]  thr_a = '0;
    logic [1:0]  thr_b = '0;
    logic [15:0] tmo_a = '0;
    logic [3:0]  tmo_b = '0;

    logic        irq_a;
    logic [7:0]  cnt_a;
    logic [1:0]  st_a;
    logic        irq_b;
    logic [1:0]  cnt_b;
    logic [1:0]  st_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    int         m_st[2];
    int         m_cnt[2];
    int         m_dl[2];
    logic [1:0] m_aq[2];
    logic       m_irq[2];

    logic [10:0] exp_qa[$];
    logic [10:0] exp_qb[$];

    always #5 clk = ~clk;

    rggen_irq_coalescer #(.TOTAL_INTERRUPTS(2), .COUNT_WIDTH(8), .TIMER_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_ier(ier), .i_isr(isr), .i_threshold(thr_a),
        .i_timeout(tmo_a), .i_ack(ack), .o_irq(irq_a), .o_pending_count(cnt_a), .o_state(st_a)
    );

    rggen_irq_coalescer #(.TOTAL_INTERRUPTS(2), .COUNT_WIDTH(2), .TIMER_WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_ier(ier), .i_isr(isr), .i_threshold(thr_b),
        .i_timeout(tmo_b), .i_ack(ack), .o_irq(irq_b), .o_pending_count(cnt_b), .o_state(st_b)
    );

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got st=%0d irq=%0d cnt=%0d, expected st=%0d irq=%0d cnt=%0d",
                     name, $time, got[10:9], got[8], got[7:0], exp[10:9], exp[8], exp[7:0]);
        end
    endtask

    // Reference: states 0 idle, 1 collecting, 2 asserted; timeout as an absolute deadline cycle.
    task automatic model_step(input int k, input int thr, input int tmo, input int maxc);
        logic [1:0] act;
        logic [1:0] rise;
        int         ev;
        if (!rst_n) begin
            m_st[k] = 0; m_cnt[k] = 0; m_aq[k] = '0; m_irq[k] = 1'b0;
        end else begin
            act = ier & isr;
            rise = act & ~m_aq[k];
            ev = $countones(rise);
            m_aq[k] = act;
            if (thr == 0) begin
                m_st[k] = 0; m_cnt[k] = 0; m_irq[k] = |act;
            end else begin
                if (m_st[k] == 0) begin
                    if (ev > 0) begin
                        m_cnt[k] = sat(ev, maxc);
                        if (m_cnt[k] >= thr) m_st[k] = 2;
                        else begin m_st[k] = 1; m_dl[k] = cyc + tmo; end
                    end
                end else if (m_st[k] == 1) begin
                    m_cnt[k] = sat(m_cnt[k] + ev, maxc);
                    if (m_cnt[k] >= thr || (tmo != 0 && cyc >= m_dl[k])) m_st[k] = 2;
                end else begin
                    m_cnt[k] = sat(m_cnt[k] + ev, maxc);
                    if (ack || act == 2'b00) begin
                        m_cnt[k] = ev;
                        if (ev == 0) m_st[k] = 0;
                        else if (ev >= thr) m_st[k] = 2;
                        else begin m_st[k] = 1; m_dl[k] = cyc + tmo; end
                    end
                end
                m_irq[k] = (m_st[k] == 2);
            end
        end
        if (k == 0) exp_qa.push_back({2'(m_st[k]), m_irq[k], 8'(m_cnt[k])});
        else        exp_qb.push_back({2'(m_st[k]), m_irq[k], 8'(m_cnt[k])});
    endtask

    task automatic step_all();
        model_step(0, int'(thr_a), int'(tmo_a), 255);
        model_step(1, int'(thr_b), int'(tmo_b), 3);
        cyc++;
    endtask

    task automatic drive(input logic [1:0] e, input logic [1:0] s, input logic a);
        @(negedge clk);
        ier = e; isr = s; ack = a;
        step_all();
    endtask

    task automatic set_cfg(input int ta, input int tb, input int to);
        @(negedge clk);
        ack = 1'b0;
        thr_a = 8'(ta); thr_b = 2'(tb); tmo_a = 16'(to); tmo_b = 4'(to);
        step_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ier = '0; isr = '0; ack = 1'b0;
        #1;
        check("async_rst_a", {st_a, irq_a, cnt_a}, 11'd0);
        check("async_rst_b", {st_b, irq_b, 6'd0, cnt_b}, 11'd0);
        step_all();
        @(negedge clk);
        step_all();
        @(negedge clk);
        rst_n = 1'b1;
        step_all();
    endtask

    initial begin
        logic [10:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_qa.size() > 0) begin
                e = exp_qa.pop_front();
                check("dut_a", {st_a, irq_a, cnt_a}, e);
            end
            if (exp_qb.size() > 0) begin
                e = exp_qb.pop_front();
                check("dut_b", {st_b, irq_b, 6'd0, cnt_b}, e);
            end
        end
    end

    initial begin
        logic [1:0] s;
        logic [1:0] en;
        int         ba;
        int         bb;
        int         to;
        do_reset();
        // bypass: registered OR
        set_cfg(0, 0, 0);
        drive(2'b11, 2'b00, 0);
        drive(2'b11, 2'b01, 0);
        drive(2'b11, 2'b01, 0);
        drive(2'b11, 2'b00, 0);
        drive(2'b11, 2'b00, 0);
        // threshold 3: two pulses, third rise held, then ack
        do_reset();
        set_cfg(3, 3, 0);
        repeat (2) begin
            drive(2'b11, 2'b01, 0);
            drive(2'b11, 2'b00, 0);
        end
        drive(2'b11, 2'b01, 0);
        drive(2'b11, 2'b01, 0);
        drive(2'b11, 2'b01, 1);
        drive(2'b11, 2'b01, 0);
        // timeout 10 with one event
        do_reset();
        set_cfg(4, 3, 10);
        drive(2'b11, 2'b01, 0);
        repeat (12) drive(2'b11, 2'b01, 0);
        drive(2'b11, 2'b01, 1);
        // simultaneous rises and saturation
        do_reset();
        set_cfg(3, 3, 0);
        drive(2'b11, 2'b11, 0);
        drive(2'b11, 2'b00, 0);
        drive(2'b11, 2'b11, 0);
        drive(2'b11, 2'b11, 0);
        // ack colliding with a rise, threshold 1 then 2
        do_reset();
        set_cfg(1, 1, 0);
        drive(2'b11, 2'b01, 0);
        drive(2'b11, 2'b11, 1);
        drive(2'b11, 2'b11, 0);
        do_reset();
        set_cfg(2, 2, 0);
        drive(2'b11, 2'b01, 0);
        drive(2'b11, 2'b11, 0);
        drive(2'b11, 2'b01, 0);
        drive(2'b11, 2'b11, 1);
        drive(2'b11, 2'b11, 0);
        // reset in the middle of collecting, then retire by clearing enables
        do_reset();
        set_cfg(3, 3, 0);
        drive(2'b11, 2'b01, 0);
        drive(2'b11, 2'b01, 0);
        do_reset();
        set_cfg(1, 1, 0);
        drive(2'b11, 2'b01, 0);
        drive(2'b00, 2'b01, 0);
        drive(2'b00, 2'b01, 0);
        // randomized segments
        repeat (8) begin
            do_reset();
            ba = $urandom_range(1, 6);
            bb = $urandom_range(1, 3);
            to = $urandom_range(0, 12);
            set_cfg(ba, bb, to);
            s = 2'b00;
            en = 2'b11;
            repeat (150) begin
                if ($urandom_range(0, 19) == 0) begin
                    if (thr_a == 8'd0) set_cfg(ba, bb, to);
                    else set_cfg(0, 0, to);
                end else begin
                    for (int i = 0; i < 2; i++) begin
                        if ($urandom_range(0, 3) == 0) s[i] = ~s[i];
                    end
                    if ($urandom_range(0, 9) == 0) en = 2'($urandom_range(0, 3));
                    drive(en, s, ($urandom_range(0, 7) == 0));
                end
            end
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_qa.size() != 0 || exp_qb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d/%0d expected entries left, required 0/0", exp_qa.size(), exp_qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rggen_irq_coalescer.md
# rggen_irq_coalescer

Parametrised interrupt controller that merges `TOTAL_INTERRUPTS` enable/status pairs from the generated register block into one interrupt line, adding per-source edge counting, count-threshold and timeout coalescing, and an explicit acknowledge. It sits beside the bus splitter, driven by `ier`/`isr` vectors assembled from `register_if[*].value` bits, and replaces the plain level-OR interrupt controller. With `i_threshold == 0` it behaves as that plain controller: a registered OR.

## Interface
- `TOTAL_INTERRUPTS`, default 2: number of sources N (≥1).
- `COUNT_WIDTH`, default 8: event counter width; must be ≥ `$clog2(N+1)`.
- `TIMER_WIDTH`, default 16: coalescing timer width.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_ier` in N: per-source enable.
- `i_isr` in N: per-source status (level).
- `i_threshold` in COUNT_WIDTH: event count that fires the irq; 0 selects bypass mode.
- `i_timeout` in TIMER_WIDTH: cycles from first event to forced fire; 0 disables the timeout.
- `i_ack` in 1: single-cycle acknowledge from software or host.
- `o_irq` out 1: interrupt request, registered.
- `o_pending_count` out COUNT_WIDTH: current event count, registered.

## Operation
- `active = i_ier & i_isr`, and `active_q` is its registered copy.
- `rise = active & ~active_q`. Events this cycle are `popcount(rise)`.
- `count_next = sat(count + popcount(rise))`. Saturation is at all-ones, so the counter never wraps.
- State machine, in coalescing mode (`i_threshold != 0`):
  - IDLE (`count == 0`):
    - If `rise != 0`, load the count.
    - If `count_next >= i_threshold`, go to ASSERT.
    - Otherwise go to COLLECT and load `timer = i_timeout`.
  - COLLECT:
    - Each cycle, accumulate the count.
    - If `i_timeout != 0`, decrement the timer.
    - Go to ASSERT when `count_next >= i_threshold`, or when `i_timeout != 0` and the timer decrements to 0.
  - ASSERT:
    - Events keep accumulating.
    - On `i_ack`, or on `active == 0` (all sources retired):
      - `count := popcount(rise)` for the same cycle.
      - Next state is IDLE if that value is 0.
      - Otherwise the next state is ASSERT if the value is ≥ threshold, else COLLECT with the timer reloaded.
- `o_irq = (state == ASSERT)`, which is a register output.
- `i_ack` outside ASSERT: no effect.
- Bypass mode (`i_threshold == 0`):
  - `o_irq` is the registered `|active`.
  - State is forced to IDLE, with count and timer cleared.
  - Switching to bypass takes effect at the next edge.
  - Switching out of bypass starts in IDLE with count 0.
- `i_threshold` and `i_timeout` are compared live. A change in COLLECT or ASSERT takes effect at the next edge, and the timer is not reloaded.
- `o_pending_count = count`.

## Timing
- Reset (async assert, sync release) sets:
  - `o_irq = 0`, `o_pending_count = 0`
  - state IDLE
  - timer 0
  - `active_q = 0`
- Latency is 1 cycle in both modes: a status rise sampled at edge k gives `o_irq = 1` after edge k (threshold reached, or bypass).
- Timeout: with the first event at edge k and no threshold hit, `o_irq` rises after edge k + `i_timeout`.
- Ack: `i_ack` high at edge k gives `o_irq = 0` after edge k, unless same-cycle events meet the threshold.
- A level held high counts as one event. It counts again only after it falls and rises again.
- Simultaneous rises on several sources add together in one cycle.
- Reset mid-COLLECT or mid-ASSERT gives immediate IDLE with all outputs 0.

## Test plan
1. Bypass: N=2, `i_threshold=0`, ier=2'b11, isr 2'b00→2'b01.
   - Required: `o_irq` 1 one cycle later.
   - Then isr→0: `o_irq` 0 one cycle later.
2. Threshold: `i_threshold=3`, `i_timeout=0`. Pulse source 0 three separate times.
   - Required: count 1,2,3, with `o_irq=1` after the third rise.
   - Then `i_ack` pulse: `o_irq=0`, count 0.
3. Timeout: `i_threshold=4`, `i_timeout=10`, a single rise at edge k.
   - Required: `o_irq=1` after edge k+10, count 1.
4. Simultaneous and saturation:
   - COUNT_WIDTH=2, N=2, threshold 3. Both sources rise together: count 2. Retire both, rise both again.
   - Required: count saturates at 3, `o_irq=1`, no wrap.
5. Ack collision: in ASSERT with threshold 1, `i_ack` in the same cycle as a new rise.
   - Required: count 1, `o_irq` stays 1.
   - The same with threshold 2: `o_irq` drops and the state is COLLECT with count 1.
6. Reset/retire:
   - Assert `rst_n=0` in COLLECT. Required: immediate count 0 and `o_irq` 0.
   - Clear `i_ier` while in ASSERT. Required: `o_irq=0` next cycle.
